// File: rtl/rename_stage.sv
// Purpose : W-wide in-order register rename with intra-group bypass and youngest-writer map update.
// Latency : 1 cycle; the accepted group appears on out_* on the clock after acceptance.
// Backpressure: the output register refills only when empty or draining; otherwise in_take=0 and out_* hold.
module rename_stage #(
  parameter int W  = 2,
  parameter int AR = 16,
  parameter int PR = 32,
  parameter int TR = 16,
  parameter int RB = 16,
  localparam int AW = $clog2(AR),
  localparam int PW = $clog2(PR),
  localparam int TW = $clog2(TR),
  localparam int RW = $clog2(RB),
  localparam int CW = $clog2(W+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [W-1:0]        in_valid,
  input  logic [W*AW-1:0]     in_rs1,
  input  logic [W*AW-1:0]     in_rs2,
  input  logic [W*AW-1:0]     in_rd,
  input  logic [W-1:0]        in_wb,
  input  logic [W-1:0]        in_wb_t,
  input  logic [W-1:0]        in_rd_t,
  output logic [CW-1:0]       in_take,
  input  logic [RW:0]         rob_avail,
  input  logic [W*RW-1:0]     rob_idx,
  input  logic [PW:0]         fl_avail,
  input  logic [W*PW-1:0]     fl_tag,
  input  logic [TW:0]         ft_avail,
  input  logic [W*TW-1:0]     ft_tag,
  output logic [CW-1:0]       fl_take,
  output logic [CW-1:0]       ft_take,
  output logic [CW-1:0]       rob_take,
  output logic [3*W*AW-1:0]   map_rd_addr,
  input  logic [3*W*PW-1:0]   map_rd_data,
  input  logic [TW-1:0]       map_t_rd_data,
  output logic [W-1:0]        map_wr_en,
  output logic [W*AW-1:0]     map_wr_addr,
  output logic [W*PW-1:0]     map_wr_data,
  output logic                map_t_wr_en,
  output logic [TW-1:0]       map_t_wr_data,
  output logic [W-1:0]        out_valid,
  output logic [W*PW-1:0]     out_p_rs1,
  output logic [W*PW-1:0]     out_p_rs2,
  output logic [W*PW-1:0]     out_p_rd,
  output logic [W*PW-1:0]     out_p_stale,
  output logic [W*TW-1:0]     out_p_t,
  output logic [W*TW-1:0]     out_t_stale,
  output logic [W*RW-1:0]     out_rob,
  input  logic                out_ready,
  output logic [15:0]         stall_cnt
);

  logic              reg_free;
  logic [W-1:0]      acc;
  logic [PW-1:0]     alloc_p [W];
  logic [TW-1:0]     alloc_t [W];
  logic              stall_hit;
  logic [W*PW-1:0]   n_rs1, n_rs2, n_rd, n_stale;
  logic [W*TW-1:0]   n_pt, n_ts;
  logic [W*RW-1:0]   n_rob;

  // Output register can take a new group when empty or being drained this cycle.
  assign reg_free = (out_valid == '0) || out_ready;

  // Accept the longest in-order prefix that fits ROB, free-list and T-list space; tags are handed out compacted.
  always_comb begin
    logic go;
    int   c_rob, c_fl, c_t, pop;
    acc   = '0;
    go    = !rst && !flush && reg_free;
    c_rob = 0;
    c_fl  = 0;
    c_t   = 0;
    pop   = 0;
    for (int i = 0; i < W; i++) begin
      alloc_p[i] = '0;
      alloc_t[i] = '0;
      if (in_valid[i]) pop = pop + 1;
      if (go && in_valid[i]
          && (c_rob + 1 <= int'(rob_avail))
          && (c_fl + int'(in_wb[i]) <= int'(fl_avail))
          && (c_t + int'(in_wb_t[i]) <= int'(ft_avail))) begin
        acc[i] = 1'b1;
        if (in_wb[i])   alloc_p[i] = fl_tag[c_fl*PW +: PW];
        if (in_wb_t[i]) alloc_t[i] = ft_tag[c_t*TW +: TW];
        c_rob = c_rob + 1;
        c_fl  = c_fl + int'(in_wb[i]);
        c_t   = c_t + int'(in_wb_t[i]);
      end else begin
        go = 1'b0;
      end
    end
    in_take   = CW'(c_rob);
    rob_take  = CW'(c_rob);
    fl_take   = CW'(c_fl);
    ft_take   = CW'(c_t);
    stall_hit = (in_valid != '0) && !flush && (c_rob < pop);
  end

  // Map-table read ports: rs1, rs2, rd for every slot.
  always_comb begin
    map_rd_addr = '0;
    for (int i = 0; i < W; i++) begin
      map_rd_addr[(3*i)*AW   +: AW] = in_rs1[i*AW +: AW];
      map_rd_addr[(3*i+1)*AW +: AW] = in_rs2[i*AW +: AW];
      map_rd_addr[(3*i+2)*AW +: AW] = in_rd[i*AW +: AW];
    end
  end

  // Resolve sources, stale tags and T mapping against older accepted writers of the same group.
  // p_t carries the new T tag for a T writer, the current T mapping for a T reader, else zero.
  always_comb begin
    logic [PW-1:0] s1, s2, st;
    logic [TW-1:0] ct;
    n_rs1 = '0; n_rs2 = '0; n_rd = '0; n_stale = '0;
    n_pt  = '0; n_ts  = '0; n_rob = '0;
    s1 = '0; s2 = '0; st = '0; ct = '0;
    for (int i = 0; i < W; i++) begin
      s1 = map_rd_data[(3*i)*PW   +: PW];
      s2 = map_rd_data[(3*i+1)*PW +: PW];
      st = map_rd_data[(3*i+2)*PW +: PW];
      ct = map_t_rd_data;
      for (int j = 0; j < i; j++) begin
        if (acc[j] && in_wb[j]) begin
          if (in_rd[j*AW +: AW] == in_rs1[i*AW +: AW]) s1 = alloc_p[j];
          if (in_rd[j*AW +: AW] == in_rs2[i*AW +: AW]) s2 = alloc_p[j];
          if (in_rd[j*AW +: AW] == in_rd[i*AW +: AW])  st = alloc_p[j];
        end
        if (acc[j] && in_wb_t[j]) ct = alloc_t[j];
      end
      n_rs1[i*PW +: PW]   = s1;
      n_rs2[i*PW +: PW]   = s2;
      n_rd[i*PW +: PW]    = alloc_p[i];
      n_stale[i*PW +: PW] = st;
      n_pt[i*TW +: TW]    = in_wb_t[i] ? alloc_t[i] : (in_rd_t[i] ? ct : '0);
      n_ts[i*TW +: TW]    = ct;
      n_rob[i*RW +: RW]   = rob_idx[i*RW +: RW];
    end
  end

  // Map writes: only the youngest accepted writer of each arch reg, and the youngest T writer.
  always_comb begin
    map_wr_en     = '0;
    map_wr_addr   = in_rd;
    map_wr_data   = '0;
    map_t_wr_en   = 1'b0;
    map_t_wr_data = '0;
    for (int i = 0; i < W; i++) begin
      map_wr_data[i*PW +: PW] = alloc_p[i];
      if (acc[i] && in_wb[i]) begin
        map_wr_en[i] = 1'b1;
        for (int j = i + 1; j < W; j++) begin
          if (acc[j] && in_wb[j] && (in_rd[j*AW +: AW] == in_rd[i*AW +: AW])) map_wr_en[i] = 1'b0;
        end
      end
      if (acc[i] && in_wb_t[i]) begin
        map_t_wr_en   = 1'b1;
        map_t_wr_data = alloc_t[i];
      end
    end
  end

  // Renamed-group output register: flush empties it, otherwise load when free, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= '0;
      out_p_rs1   <= '0;
      out_p_rs2   <= '0;
      out_p_rd    <= '0;
      out_p_stale <= '0;
      out_p_t     <= '0;
      out_t_stale <= '0;
      out_rob     <= '0;
    end else if (flush) begin
      out_valid <= '0;
    end else if (reg_free) begin
      out_valid   <= acc;
      out_p_rs1   <= n_rs1;
      out_p_rs2   <= n_rs2;
      out_p_rd    <= n_rd;
      out_p_stale <= n_stale;
      out_p_t     <= n_pt;
      out_t_stale <= n_ts;
      out_rob     <= n_rob;
    end
  end

  // Saturating count of cycles where some valid slot was held back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_hit && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
module tb_rename_stage;
  localparam int W = 2, AW = 4, PW = 5, TW = 4, RW = 4, CW = 2;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic [W-1:0]      in_valid, in_wb, in_wb_t, in_rd_t;
  logic [W*AW-1:0]   in_rs1, in_rs2, in_rd;
  logic [CW-1:0]     in_take, fl_take, ft_take, rob_take;
  logic [RW:0]       rob_avail;
  logic [W*RW-1:0]   rob_idx;
  logic [PW:0]       fl_avail;
  logic [W*PW-1:0]   fl_tag;
  logic [TW:0]       ft_avail;
  logic [W*TW-1:0]   ft_tag;
  logic [3*W*AW-1:0] map_rd_addr;
  logic [3*W*PW-1:0] map_rd_data;
  logic [TW-1:0]     map_t_rd_data;
  logic [W-1:0]      map_wr_en;
  logic [W*AW-1:0]   map_wr_addr;
  logic [W*PW-1:0]   map_wr_data;
  logic              map_t_wr_en;
  logic [TW-1:0]     map_t_wr_data;
  logic [W-1:0]      out_valid;
  logic [W*PW-1:0]   out_p_rs1, out_p_rs2, out_p_rd, out_p_stale;
  logic [W*TW-1:0]   out_p_t, out_t_stale;
  logic [W*RW-1:0]   out_rob;
  logic              out_ready;
  logic [15:0]       stall_cnt;

  rename_stage #(.W(2), .AR(16), .PR(32), .TR(16), .RB(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_wb(in_wb), .in_wb_t(in_wb_t), .in_rd_t(in_rd_t), .in_take(in_take),
    .rob_avail(rob_avail), .rob_idx(rob_idx), .fl_avail(fl_avail), .fl_tag(fl_tag),
    .ft_avail(ft_avail), .ft_tag(ft_tag), .fl_take(fl_take), .ft_take(ft_take), .rob_take(rob_take),
    .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data), .map_t_rd_data(map_t_rd_data),
    .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
    .map_t_wr_en(map_t_wr_en), .map_t_wr_data(map_t_wr_data),
    .out_valid(out_valid), .out_p_rs1(out_p_rs1), .out_p_rs2(out_p_rs2), .out_p_rd(out_p_rd),
    .out_p_stale(out_p_stale), .out_p_t(out_p_t), .out_t_stale(out_t_stale), .out_rob(out_rob),
    .out_ready(out_ready), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Fixed map table: arch reg a maps to preg a+16; T maps to 9.
  always_comb begin
    map_rd_data = '0;
    for (int i = 0; i < 3*W; i++) map_rd_data[i*PW +: PW] = {1'b1, map_rd_addr[i*AW +: AW]};
  end
  assign map_t_rd_data = 4'd9;

  typedef struct {
    logic [1:0] v;
    logic [9:0] rs1, rs2, rd, st;
    logic [7:0] pt, ts, rob;
  } grp_t;

  grp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] m10(input logic [1:0] v);
    return {{5{v[1]}}, {5{v[0]}}};
  endfunction
  function automatic logic [7:0] m8(input logic [1:0] v);
    return {{4{v[1]}}, {4{v[0]}}};
  endfunction

  task automatic push(input logic [1:0] v, input logic [9:0] rs1, rs2, rd, st,
                      input logic [7:0] pt, ts, rob);
    grp_t g;
    g.v = v; g.rs1 = rs1; g.rs2 = rs2; g.rd = rd; g.st = st; g.pt = pt; g.ts = ts; g.rob = rob;
    exp_q.push_back(g);
  endtask

  // Monitor: each group handed to dispatch is compared against the oldest expectation.
  initial begin : monitor
    grp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_ready && (out_valid != 2'b00)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_group: got valid=%b want none", out_valid);
        end else begin
          e = exp_q.pop_front();
          chk("grp_valid", 32'(out_valid), 32'(e.v));
          chk("grp_p_rs1", 32'(out_p_rs1 & m10(e.v)), 32'(e.rs1 & m10(e.v)));
          chk("grp_p_rs2", 32'(out_p_rs2 & m10(e.v)), 32'(e.rs2 & m10(e.v)));
          chk("grp_p_rd", 32'(out_p_rd & m10(e.v)), 32'(e.rd & m10(e.v)));
          chk("grp_p_stale", 32'(out_p_stale & m10(e.v)), 32'(e.st & m10(e.v)));
          chk("grp_p_t", 32'(out_p_t & m8(e.v)), 32'(e.pt & m8(e.v)));
          chk("grp_t_stale", 32'(out_t_stale & m8(e.v)), 32'(e.ts & m8(e.v)));
          chk("grp_rob", 32'(out_rob & m8(e.v)), 32'(e.rob & m8(e.v)));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic clr_in();
    in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_wb = '0; in_wb_t = '0; in_rd_t = '0;
  endtask

  task automatic slot(input int i, input logic [3:0] r1, r2, d, input logic wb, wbt, rdt);
    in_valid[i] = 1'b1;
    in_rs1[i*AW +: AW] = r1;
    in_rs2[i*AW +: AW] = r2;
    in_rd[i*AW +: AW]  = d;
    in_wb[i] = wb; in_wb_t[i] = wbt; in_rd_t[i] = rdt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pop(input string nm, input int k, input int fl, input int ft);
    #1;
    chk({nm, "_take"}, 32'(in_take), k);
    chk({nm, "_rob_take"}, 32'(rob_take), k);
    chk({nm, "_fl_take"}, 32'(fl_take), fl);
    chk({nm, "_ft_take"}, 32'(ft_take), ft);
  endtask

  initial begin : stim
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    clr_in();
    rob_avail = 5'd16; fl_avail = 6'd32; ft_avail = 5'd16;
    fl_tag = {5'd21, 5'd20}; ft_tag = {4'd4, 4'd3}; rob_idx = {4'd8, 4'd7};

    // Reset: valid input present, nothing consumed, register and counter zero
    slot(0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    #12;
    chk_pop("rst", 0, 0, 0);
    chk("rst_map_wr_en", 32'(map_wr_en), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_p_rd", 32'(out_p_rd), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    clr_in();
    step();

    // 1: independent ops, ample resources
    slot(0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    slot(1, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0, 1'b0);
    chk_pop("t1", 2, 2, 0);
    chk("t1_wr_en", 32'(map_wr_en), 3);
    chk("t1_wr_addr", 32'(map_wr_addr), 32'({4'd6, 4'd3}));
    chk("t1_wr_data", 32'(map_wr_data), 32'({5'd21, 5'd20}));
    chk("t1_t_wr_en", 32'(map_t_wr_en), 0);
    push(2'b11, {5'd20, 5'd17}, {5'd21, 5'd18}, {5'd21, 5'd20}, {5'd22, 5'd19},
         8'h00, {4'd9, 4'd9}, {4'd8, 4'd7});
    step();

    // 2: RAW bypass from slot0 rd, plus T writer -> T reader
    clr_in();
    slot(0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    slot(1, 4'd3, 4'd3, 4'd7, 1'b1, 1'b0, 1'b1);
    chk_pop("t2", 2, 2, 1);
    chk("t2_wr_en", 32'(map_wr_en), 3);
    chk("t2_t_wr_en", 32'(map_t_wr_en), 1);
    chk("t2_t_wr_data", 32'(map_t_wr_data), 3);
    push(2'b11, {5'd20, 5'd17}, {5'd20, 5'd18}, {5'd21, 5'd20}, {5'd23, 5'd19},
         {4'd3, 4'd3}, {4'd3, 4'd9}, {4'd8, 4'd7});
    step();

    // 3: WAW on D5, both write T
    clr_in();
    slot(0, 4'd0, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0);
    slot(1, 4'd2, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
    chk_pop("t3", 2, 2, 2);
    chk("t3_wr_en", 32'(map_wr_en), 2);
    chk("t3_wr_addr", 32'(map_wr_addr), 32'({4'd5, 4'd5}));
    chk("t3_wr_data_slot1", 32'(map_wr_data[9:5]), 21);
    chk("t3_t_wr_data", 32'(map_t_wr_data), 4);
    push(2'b11, {5'd18, 5'd16}, {5'd20, 5'd17}, {5'd21, 5'd20}, {5'd20, 5'd21},
         {4'd4, 4'd3}, {4'd3, 4'd9}, {4'd8, 4'd7});
    step();

    // 4: compacted tags: only slot1 writes, one free preg and one free T
    clr_in();
    fl_avail = 6'd1; ft_avail = 5'd1;
    slot(0, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    slot(1, 4'd0, 4'd1, 4'd4, 1'b1, 1'b1, 1'b0);
    chk_pop("t4", 2, 1, 1);
    chk("t4_wr_en", 32'(map_wr_en), 2);
    chk("t4_wr_data", 32'(map_wr_data), 32'({5'd20, 5'd0}));
    chk("t4_t_wr_data", 32'(map_t_wr_data), 3);
    push(2'b11, {5'd16, 5'd17}, {5'd17, 5'd18}, {5'd20, 5'd0}, {5'd20, 5'd16},
         {4'd3, 4'd0}, {4'd9, 4'd9}, {4'd8, 4'd7});
    step();

    // 5a: no free pregs, oldest slot writes -> nothing taken
    clr_in();
    fl_avail = 6'd0; ft_avail = 5'd16;
    slot(0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    slot(1, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0);
    chk_pop("t5a", 0, 0, 0);
    chk("t5a_wr_en", 32'(map_wr_en), 0);
    exp_stall++;
    step();

    // 5b: one free preg, two writers -> prefix of one
    clr_in();
    fl_avail = 6'd1;
    slot(0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    slot(1, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0, 1'b0);
    chk_pop("t5b", 1, 1, 0);
    chk("t5b_wr_en", 32'(map_wr_en), 1);
    exp_stall++;
    push(2'b01, {5'd0, 5'd17}, {5'd0, 5'd18}, {5'd0, 5'd20}, {5'd0, 5'd19},
         8'h00, {4'd0, 4'd9}, {4'd0, 4'd7});
    step();

    // 5c: one free ROB entry
    clr_in();
    fl_avail = 6'd32; rob_avail = 5'd1;
    slot(0, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    slot(1, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0);
    chk_pop("t5c", 1, 0, 0);
    exp_stall++;
    push(2'b01, {5'd0, 5'd18}, {5'd0, 5'd19}, 10'd0, {5'd0, 5'd16},
         8'h00, {4'd0, 4'd9}, {4'd0, 4'd7});
    step();
    rob_avail = 5'd16;
    clr_in();
    step();
    chk("t5c_drained_valid", 32'(out_valid), 0);
    chk("t5c_stall", 32'(stall_cnt), 32'(exp_stall));

    // 5d: dispatch backpressure holds the register and blocks intake
    out_ready = 1'b0;
    slot(0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    slot(1, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0, 1'b0);
    chk_pop("t5d_load", 2, 2, 0);
    push(2'b11, {5'd20, 5'd17}, {5'd21, 5'd18}, {5'd21, 5'd20}, {5'd22, 5'd19},
         8'h00, {4'd9, 4'd9}, {4'd8, 4'd7});
    step();
    chk_pop("t5d_full", 0, 0, 0);
    chk("t5d_valid", 32'(out_valid), 3);
    chk("t5d_p_rd", 32'(out_p_rd), 32'({5'd21, 5'd20}));
    exp_stall++;
    step();
    chk("t5d_hold_valid", 32'(out_valid), 3);
    chk("t5d_hold_rs1", 32'(out_p_rs1), 32'({5'd20, 5'd17}));
    chk("t5d_stall", 32'(stall_cnt), 32'(exp_stall));
    // Drain and refill in the same cycle
    out_ready = 1'b1;
    clr_in();
    slot(0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    slot(1, 4'd3, 4'd3, 4'd7, 1'b1, 1'b0, 1'b1);
    chk_pop("t5d_refill", 2, 2, 1);
    push(2'b11, {5'd20, 5'd17}, {5'd20, 5'd18}, {5'd21, 5'd20}, {5'd23, 5'd19},
         {4'd3, 4'd3}, {4'd3, 4'd9}, {4'd8, 4'd7});
    step();
    clr_in();
    step();

    // 6: flush while full and blocked
    out_ready = 1'b0;
    slot(0, 4'd0, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0);
    slot(1, 4'd2, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
    chk_pop("t6_load", 2, 2, 2);
    push(2'b11, {5'd18, 5'd16}, {5'd20, 5'd17}, {5'd21, 5'd20}, {5'd20, 5'd21},
         {4'd4, 4'd3}, {4'd3, 4'd9}, {4'd8, 4'd7});
    step();
    flush = 1'b1;
    chk_pop("t6_flush", 0, 0, 0);
    chk("t6_flush_wr_en", 32'(map_wr_en), 0);
    chk("t6_flush_t_wr_en", 32'(map_t_wr_en), 0);
    step();
    flush = 1'b0;
    void'(exp_q.pop_back());
    chk("t6_valid_cleared", 32'(out_valid), 0);
    chk("t6_stall", 32'(stall_cnt), 32'(exp_stall));
    clr_in();
    step();

    // 6b: reset mid-run with a held group
    slot(0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    slot(1, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0, 1'b0);
    push(2'b11, {5'd20, 5'd17}, {5'd21, 5'd18}, {5'd21, 5'd20}, {5'd22, 5'd19},
         8'h00, {4'd9, 4'd9}, {4'd8, 4'd7});
    step();
    rst = 1'b1;
    chk_pop("t6_rst", 0, 0, 0);
    chk("t6_rst_wr_en", 32'(map_wr_en), 0);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_p_rd", 32'(out_p_rd), 0);
    chk("t6_rst_rob", 32'(out_rob), 0);
    chk("t6_rst_stall", 32'(stall_cnt), 0);
    void'(exp_q.pop_back());
    step();
    rst = 1'b0;
    clr_in();
    out_ready = 1'b1;
    step();

    // Recovery after reset
    slot(0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    slot(1, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0, 1'b0);
    chk_pop("t7", 2, 2, 0);
    push(2'b11, {5'd20, 5'd17}, {5'd21, 5'd18}, {5'd21, 5'd20}, {5'd22, 5'd19},
         8'h00, {4'd9, 4'd9}, {4'd8, 4'd7});
    step();
    clr_in();
    step();
    step();

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
